// File: rtl/sd_pkg.sv
// Shared constants and arithmetic helpers for the second-order sigma-delta transmitter.
package sd_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ACC_GUARD      = 4;

  function automatic int acc_width(input int dw);
    return dw + ACC_GUARD;
  endfunction

  function automatic longint full_scale(input int dw);
    return longint'(1) <<< (dw - 1);
  endfunction

  // Input headroom of 3/4 FS keeps the second-order loop out of overload.
  function automatic longint max_in(input int dw);
    return 3 * (longint'(1) <<< (dw - 3));
  endfunction

  function automatic longint clamp_in(input longint v, input int dw);
    longint lim;
    lim = max_in(dw);
    if (v > lim)       return lim;
    else if (v < -lim) return -lim;
    else               return v;
  endfunction

  function automatic longint sat_acc(input longint v, input int aw);
    longint hi, lo;
    hi = (longint'(1) <<< (aw - 1)) - 1;
    lo = -(longint'(1) <<< (aw - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/sd_mod2_core.sv
// Second-order 1-bit loop: two saturating integrators, sign quantiser, +/-FS feedback.
// SD_TX_DITHER_EN adds a +/-1 LSB LFSR dither into the first integrator.
module sd_mod2_core
  import sd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = DATA_WIDTH + 4
) (
  input  logic                         clock,
  input  logic                         sclr_n,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] active,
  output logic                         sdo
);

  localparam longint FS = full_scale(DATA_WIDTH);

  logic signed [ACC_WIDTH-1:0] i1_q, i1_d, i2_q, i2_d;
  logic                        sdo_q, sdo_d;
  logic signed [63:0]          fb, dith;

`ifdef SD_TX_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (enable) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    dith = lfsr_q[0] ? 64'sd1 : -64'sd1;
  end

  always_ff @(posedge clock) begin
    if (!sclr_n) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end
`else
  assign dith = 64'sd0;
`endif

  always_comb begin
    fb    = sdo_q ? FS : -FS;
    i1_d  = ACC_WIDTH'(sat_acc(longint'(i1_q) + longint'(active) - fb + dith, ACC_WIDTH));
    i2_d  = ACC_WIDTH'(sat_acc(longint'(i2_q) + longint'(i1_q) - fb, ACC_WIDTH));
    sdo_d = ~i2_d[ACC_WIDTH-1];
    // Idle: clear the loop and emit a zero-mean alternating pattern.
    if (!enable) begin
      i1_d  = '0;
      i2_d  = '0;
      sdo_d = ~sdo_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      i1_q  <= '0;
      i2_q  <= '0;
      sdo_q <= 1'b0;
    end else begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      sdo_q <= sdo_d;
    end
  end

  assign sdo = sdo_q;

endmodule

// File: rtl/sd_mod2_tx.sv
// Sigma-delta transmitter top: valid/ready holding register, OSR period counter, tick/underrun pulses.
// Optional dither in the loop core is enabled with SD_TX_DITHER_EN.
module sd_mod2_tx
  import sd_pkg::*;
#(
  parameter int OSR_WIDTH  = 7,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = DATA_WIDTH + 4
) (
  input  logic                         clock,
  input  logic                         sclr_n,
  input  logic                         enable,
  input  logic [OSR_WIDTH-1:0]         osr,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic                         din_valid,
  output logic                         din_ready,
  output logic                         sdo,
  output logic                         sample_tick,
  output logic                         underrun
);

  logic signed [DATA_WIDTH-1:0] hold_q, hold_d, active_q, active_d;
  logic                         hold_full_q, hold_full_d;
  logic [OSR_WIDTH-1:0]         cnt_q, cnt_d, osr_q, osr_d;
  logic                         tick_q, tick_d, under_q, under_d;
  logic                         accept, hit;

  assign din_ready = sclr_n & ~hold_full_q;
  assign accept    = din_valid & din_ready;
  assign hit       = (cnt_q == osr_q);

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    active_d    = active_q;
    cnt_d       = cnt_q;
    osr_d       = osr_q;
    tick_d      = 1'b0;
    under_d     = 1'b0;
    // Accept only happens with hold empty, so it never collides with the hold drain below.
    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end
    if (enable) begin
      if (hit) begin
        cnt_d  = '0;
        osr_d  = osr;
        tick_d = 1'b1;
        if (hold_full_q) begin
          active_d    = DATA_WIDTH'(clamp_in(longint'(hold_q), DATA_WIDTH));
          hold_full_d = 1'b0;
        end else begin
          under_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      active_q    <= '0;
      cnt_q       <= '0;
      osr_q       <= '0;
      tick_q      <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      osr_q       <= osr_d;
      tick_q      <= tick_d;
      under_q     <= under_d;
    end
  end

  assign sample_tick = tick_q;
  assign underrun    = under_q;

  sd_mod2_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_core (
    .clock (clock),
    .sclr_n(sclr_n),
    .enable(enable),
    .active(active_q),
    .sdo   (sdo)
  );

endmodule

// File: tb/tb_sd_mod2_tx.sv
// Self-checking bench for sd_mod2_tx: cycle model with a queue-based holding register,
// density table, handshake/underrun/OSR-change sequences and a randomized phase.
module tb_sd_mod2_tx;

  localparam int     DW    = 16;
  localparam int     OW    = 7;
  localparam longint FS    = 32768;
  localparam longint MAXIN = 24576;
  localparam longint AMAX  = 524287;
  localparam longint AMIN  = -524288;

  logic                 clock = 1'b0;
  logic                 sclr_n, enable, din_valid;
  logic [OW-1:0]        osr;
  logic signed [DW-1:0] din;
  logic                 din_ready, sdo, sample_tick, underrun;

  always #5 clock = ~clock;

  sd_mod2_tx #(.OSR_WIDTH(OW), .DATA_WIDTH(DW)) dut (
    .clock      (clock),
    .sclr_n     (sclr_n),
    .enable     (enable),
    .osr        (osr),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sdo        (sdo),
    .sample_tick(sample_tick),
    .underrun   (underrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain integer arithmetic, holding register as a queue.
  int     mq[$];
  longint m_active = 0, m_i1 = 0, m_i2 = 0, m_fb, m_n1, m_n2;
  int     m_cnt = 0, m_osr = 0;
  bit     m_sdo = 0, m_tick = 0, m_under = 0, m_acc = 0;

  function automatic longint msat(input longint v);
    return (v > AMAX) ? AMAX : (v < AMIN) ? AMIN : v;
  endfunction

  function automatic longint mclamp(input longint v);
    return (v > MAXIN) ? MAXIN : (v < -MAXIN) ? -MAXIN : v;
  endfunction

  always @(posedge clock) begin
    if (!sclr_n) begin
      mq.delete();
      m_active = 0; m_cnt = 0; m_osr = 0; m_i1 = 0; m_i2 = 0;
      m_sdo = 0; m_tick = 0; m_under = 0; m_acc = 0;
    end else begin
      m_acc   = din_valid && (mq.size() == 0);
      m_tick  = 0;
      m_under = 0;
      if (enable) begin
        m_fb  = m_sdo ? FS : -FS;
        m_n1  = msat(m_i1 + m_active - m_fb);
        m_n2  = msat(m_i2 + m_i1 - m_fb);
        m_i1  = m_n1;
        m_i2  = m_n2;
        m_sdo = (m_n2 >= 0);
        if (m_cnt == m_osr) begin
          m_cnt  = 0;
          m_osr  = int'(osr);
          m_tick = 1;
          if (mq.size() > 0) m_active = mclamp(longint'(mq.pop_front()));
          else               m_under  = 1;
        end else begin
          m_cnt++;
        end
      end else begin
        m_cnt = 0; m_i1 = 0; m_i2 = 0;
        m_sdo = !m_sdo;
      end
      if (m_acc) mq.push_back(int'(din));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  int ones_cnt = 0, tick_cnt = 0, und_cnt = 0, rdy_cnt = 0;

  task automatic cyc();
    @(posedge clock);
    #2;
    check("sdo",         sdo,         m_sdo);
    check("din_ready",   din_ready,   sclr_n && (mq.size() == 0));
    check("sample_tick", sample_tick, m_tick);
    check("underrun",    underrun,    m_under);
    ones_cnt += int'(sdo);
    tick_cnt += int'(sample_tick);
    und_cnt  += int'(underrun);
    rdy_cnt  += int'(din_ready);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clr_counts();
    ones_cnt = 0; tick_cnt = 0; und_cnt = 0; rdy_cnt = 0;
  endtask

  typedef struct {
    logic signed [DW-1:0] d;
    int                   exp_ones;
  } dens_t;

  dens_t tbl[5];

  initial begin
    tbl[0] = '{16'sd0,      2048};
    tbl[1] = '{16'sd8192,   2560};
    tbl[2] = '{-16'sd8192,  1536};
    tbl[3] = '{16'sd32767,  3584};
    tbl[4] = '{-16'sd32768, 512};

    // Reset held for three clocks with valid data offered.
    sclr_n = 0; enable = 0; din_valid = 1; din = 16'sd5; osr = '0;
    run(3);
    check("rst_sdo",       sdo,         1'b0);
    check("rst_din_ready", din_ready,   1'b0);
    check("rst_tick",      sample_tick, 1'b0);
    check("rst_underrun",  underrun,    1'b0);
    sclr_n = 1;
    #1;
    check("rel_din_ready", din_ready, 1'b1);

    // Density table: constant stream at osr=127.
    enable = 1; osr = 7'd127; din_valid = 1;
    foreach (tbl[k]) begin
      din = tbl[k].d;
      run(512);
      clr_counts();
      run(4096);
      n_tests++;
      if (ones_cnt > tbl[k].exp_ones + 8 || ones_cnt < tbl[k].exp_ones - 8) begin
        n_fail++;
        $display("FAIL density[%0d] din=%0d: ones %0d required %0d+/-8", k, tbl[k].d, ones_cnt, tbl[k].exp_ones);
      end
    end

    // Handshake at osr=3 with incrementing data.
    sclr_n = 0; run(1); sclr_n = 1;
    osr = 7'd3; din = 16'sd100; din_valid = 1;
    for (int i = 0; i < 16; i++) begin cyc(); if (m_acc) din = din + 1'b1; end
    clr_counts();
    for (int i = 0; i < 40; i++) begin cyc(); if (m_acc) din = din + 1'b1; end
    check("hs_ticks",    tick_cnt, 10);
    check("hs_ready",    rdy_cnt,  10);
    check("hs_underrun", und_cnt,  0);

    // Underrun at osr=7: last value repeats, underrun on every tick.
    osr = 7'd7; din_valid = 0;
    run(24);
    clr_counts();
    run(32);
    check("ur_ticks",    tick_cnt, 4);
    check("ur_underrun", und_cnt,  4);

    // OSR change mid-period: current period stays 8, following period is 16.
    begin
      int n;
      n = 0;
      do begin cyc(); n++; end while (!sample_tick && n < 64);
      check("osr_sync", sample_tick, 1'b1);
      run(3);
      osr = 7'd15;
      n = 3;
      do begin cyc(); n++; end while (!sample_tick && n < 64);
      check("osr_period_old", n, 8);
      n = 0;
      do begin cyc(); n++; end while (!sample_tick && n < 64);
      check("osr_period_new", n, 16);
    end

    // Idle: toggling output, no pulses, hold still accepts.
    enable = 0; din_valid = 1; din = -16'sd1234;
    clr_counts();
    run(10);
    check("idle_ticks", tick_cnt, 0);
    check("idle_ones",  ones_cnt, 5);
    enable = 1;
    run(40);

    // Randomized phase including occasional reset and enable drops.
    for (int i = 0; i < 3000; i++) begin
      sclr_n    = ($urandom_range(99) != 0);
      enable    = ($urandom_range(9) != 0);
      din_valid = ($urandom_range(9) < 7);
      din       = DW'($urandom);
      if ($urandom_range(31) == 0) osr = OW'($urandom_range(15));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
